// File: rtl/spi_slave_mem.sv
// spi_slave_mem: SPI mode-0 slave emulating a small 25AA010A-style serial EEPROM
module spi_slave_mem #(
  parameter int ADDR_W = 7,
  parameter int PAGE_SIZE = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              csn,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE} state_t;
  state_t state_q, state_d, cmd_next;
  logic [SYNC_STAGES:0] sck_q, sck_d, csn_q, csn_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] sh_in_q, sh_in_d;
  logic [7:0] sh_out_q, sh_out_d, byte_in, out_byte;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_page_inc, wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic wel_q, wel_d, is_wr_q, is_wr_d, miso_q, miso_d, wr_stb_q, wr_stb_d, mem_we;
  logic sck_rise, sck_fall, csn_hi, csn_fall, byte_done;
  logic [7:0] mem [DEPTH];
  assign sck_d = {sck_q[SYNC_STAGES-1:0], sck};
  assign csn_d = {csn_q[SYNC_STAGES-1:0], csn};
  assign mosi_d = {mosi_q[SYNC_STAGES-2:0], mosi};
  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
  assign csn_hi = csn_q[SYNC_STAGES-1];
  assign csn_fall = ~csn_q[SYNC_STAGES-1] & csn_q[SYNC_STAGES];
  assign byte_in = {sh_in_q, mosi_q[SYNC_STAGES-1]};
  assign byte_done = sck_rise && bit_q == 3'd7 && state_q != IDLE;
  assign out_byte = state_q == STATUS ? {6'b0, wel_q, 1'b0} : mem[ptr_q];
  assign ptr_page_inc = (ptr_q & ~PAGE_MASK) | ((ptr_q + 1'b1) & PAGE_MASK);
  assign cmd_next = byte_in == 8'h03 ? ADDR :
                    byte_in == 8'h02 && wel_q ? ADDR :
                    byte_in == 8'h05 ? STATUS : IGNORE;
  assign miso = miso_q;
  assign wr_stb = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (csn_hi) state_d = IDLE;
    else if (csn_fall) state_d = CMD;
    else if (byte_done)
      state_d = state_q == CMD ? cmd_next :
                state_q == ADDR ? (is_wr_q ? WR_DATA : RD_DATA) : state_q;
  end
  always_comb begin
    wel_d = wel_q;
    is_wr_d = is_wr_q;
    bit_d = bit_q;
    sh_in_d = sh_in_q;
    sh_out_d = sh_out_q;
    ptr_d = ptr_q;
    miso_d = miso_q;
    wr_stb_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we = 1'b0;
    if (csn_hi) begin
      bit_d = '0;
      miso_d = 1'b0;
      is_wr_d = 1'b0;
      wel_d = is_wr_q ? 1'b0 : wel_q;
    end else if (csn_fall) begin
      bit_d = '0;
      sh_in_d = '0;
    end else if (state_q != IDLE && sck_rise) begin
      sh_in_d = byte_in[6:0];
      bit_d = bit_q + 3'd1;
      if (byte_done && state_q == CMD) begin
        wel_d = byte_in == 8'h06 ? 1'b1 : byte_in == 8'h04 ? 1'b0 : wel_q;
        is_wr_d = byte_in == 8'h02;
      end
      if (byte_done && state_q == ADDR) ptr_d = byte_in[ADDR_W-1:0];
      if (byte_done && state_q == RD_DATA) ptr_d = ptr_q + 1'b1;
      if (byte_done && state_q == WR_DATA) begin
        mem_we = 1'b1;
        wr_stb_d = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = byte_in;
        ptr_d = ptr_page_inc;
      end
    end else if (state_q != IDLE && sck_fall) begin
      miso_d = 1'b0;
      if (state_q == RD_DATA || state_q == STATUS) begin
        miso_d = bit_q == 3'd0 ? out_byte[7] : sh_out_q[7];
        sh_out_d = bit_q == 3'd0 ? {out_byte[6:0], 1'b0} : {sh_out_q[6:0], 1'b0};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= '0;
      csn_q <= '0;
      mosi_q <= '0;
      bit_q <= '0;
      sh_in_q <= '0;
      sh_out_q <= '0;
      ptr_q <= '0;
      wel_q <= 1'b0;
      is_wr_q <= 1'b0;
      miso_q <= 1'b0;
      wr_stb_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      sck_q <= sck_d;
      csn_q <= csn_d;
      mosi_q <= mosi_d;
      bit_q <= bit_d;
      sh_in_q <= sh_in_d;
      sh_out_q <= sh_out_d;
      ptr_q <= ptr_d;
      wel_q <= wel_d;
      is_wr_q <= is_wr_d;
      miso_q <= miso_d;
      wr_stb_q <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr_q] <= byte_in;
  end
endmodule

// File: tb/tb_spi_slave_mem.sv
// tb_spi_slave_mem: directed scoreboard bench for the SPI EEPROM responder
module tb_spi_slave_mem;
  localparam int HALF = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic csn = 1'b1;
  logic mosi = 1'b0;
  logic miso, wr_stb;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mem_m [128];
  logic wel_m = 1'b0;
  logic [7:0] rd_exp [$];
  logic [14:0] wr_exp [$];
  logic [14:0] wr_obs [$];
  logic [7:0] r;
  spi_slave_mem dut (
    .clk(clk), .rst(rst), .sck(sck), .csn(csn), .mosi(mosi),
    .miso(miso), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (wr_stb) wr_obs.push_back({wr_addr, wr_data});
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask
  task automatic cs_low();
    @(negedge clk);
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask
  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask
  task automatic cmd_txn(input logic [7:0] c);
    logic [7:0] x;
    cs_low();
    spi_byte(c, x);
    cs_high();
    if (c == 8'h06) wel_m = 1'b1;
    if (c == 8'h04) wel_m = 1'b0;
  endtask
  task automatic check_writes(input string tag);
    check({tag, "_count"}, 32'(wr_obs.size()), 32'(wr_exp.size()));
    while (wr_exp.size() > 0 && wr_obs.size() > 0)
      check(tag, 32'(wr_obs.pop_front()), 32'(wr_exp.pop_front()));
    wr_exp.delete();
    wr_obs.delete();
  endtask
  task automatic read_txn(input string tag, input logic [6:0] a, input int n);
    logic [7:0] x;
    logic [6:0] idx;
    cs_low();
    spi_byte(8'h03, x);
    spi_byte({1'b1, a}, x);
    for (int i = 0; i < n; i++) begin
      idx = a + 7'(i);
      rd_exp.push_back(mem_m[idx]);
    end
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, x);
      check(tag, 32'(x), 32'(rd_exp.pop_front()));
    end
    cs_high();
  endtask
  task automatic rdsr_txn(input string tag, input int n);
    logic [7:0] x;
    cs_low();
    spi_byte(8'h05, x);
    for (int i = 0; i < n; i++) rd_exp.push_back({6'b0, wel_m, 1'b0});
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, x);
      check(tag, 32'(x), 32'(rd_exp.pop_front()));
    end
    cs_high();
  endtask
  task automatic write_txn(input string tag, input logic [6:0] a, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] x;
    logic [6:0] p;
    logic [7:0] b [3];
    b[0] = b0;
    b[1] = b1;
    b[2] = b2;
    p = a;
    cs_low();
    spi_byte(8'h02, x);
    spi_byte({1'b0, a}, x);
    for (int i = 0; i < n; i++) begin
      if (wel_m) begin
        wr_exp.push_back({p, b[i]});
        mem_m[p] = b[i];
      end
      p = {p[6:4], p[3:0] + 4'd1};
      spi_byte(b[i], x);
    end
    cs_high();
    wel_m = 1'b0;
    check_writes(tag);
  endtask
  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    rdsr_txn("rdsr_reset", 2);
    cmd_txn(8'h06);
    rdsr_txn("rdsr_wren", 2);
    cmd_txn(8'h04);
    rdsr_txn("rdsr_wrdi", 1);
    cmd_txn(8'h06);
    write_txn("wr_basic", 7'h10, 2, 8'hA5, 8'h5A, 8'h00);
    read_txn("rd_basic", 7'h10, 2);
    rdsr_txn("rdsr_autoclr", 1);
    cmd_txn(8'h06);
    write_txn("wr_seed", 7'h20, 1, 8'h3C, 8'h00, 8'h00);
    write_txn("wr_nowel", 7'h20, 1, 8'hFF, 8'h00, 8'h00);
    read_txn("rd_nowel", 7'h20, 1);
    cmd_txn(8'h06);
    write_txn("wr_page", 7'h1E, 3, 8'h01, 8'h02, 8'h03);
    read_txn("rd_page", 7'h1E, 2);
    read_txn("rd_page_wrap", 7'h10, 1);
    cmd_txn(8'h06);
    write_txn("wr_top", 7'h7F, 1, 8'h77, 8'h00, 8'h00);
    cmd_txn(8'h06);
    write_txn("wr_bottom", 7'h00, 1, 8'h88, 8'h00, 8'h00);
    read_txn("rd_wrap", 7'h7F, 2);
    cmd_txn(8'h06);
    cs_low();
    spi_byte(8'h02, r);
    spi_byte(8'h40, r);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    cs_high();
    wel_m = 1'b0;
    check_writes("partial");
    rdsr_txn("rdsr_partial", 1);
    cs_low();
    spi_byte(8'h03, r);
    spi_byte(8'hFF, r);
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    check("rd_bit7", 32'(miso), 32'(mem_m[7'h7F][7]));
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
    repeat (HALF) @(negedge clk);
    check("rd_bit6", 32'(miso), 32'(mem_m[7'h7F][6]));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_miso", 32'(miso), 32'd0);
    rst = 1'b0;
    spi_byte(8'h06, r);
    cs_high();
    check_writes("rst_nowr");
    rdsr_txn("rdsr_after_rst", 1);
    read_txn("rd_after_rst", 7'h10, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave_mem.md
Name: spi_slave_mem

Overview:
- SPI mode-0 slave responder emulating a small serial EEPROM with a 25AA010A-style command set.
- It is the far end of the SPI master link. It stands in for the external memory in simulation and FPGA loopback builds.
- Runs entirely in the system clock domain. sck, csn and mosi are oversampled through synchronisers and edge-detected.

Parameters:
- ADDR_W, 7, memory address width; depth = 2**ADDR_W bytes (128).
- PAGE_SIZE, 16, write page size in bytes; power of two, ≤ depth.
- SYNC_STAGES, 2, synchroniser flops on sck/csn/mosi (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock from master (async to clk).
- csn  in  1  chip select, active low (async).
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first; 0 when not driving.
- wr_stb  out  1  one-clk pulse when a data byte is committed to memory.
- wr_addr  out  ADDR_W  address of committed byte.
- wr_data  out  8  committed byte.

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-high (rst).
- Reset values:
  - miso=0, wr_stb=0, wr_addr=0, wr_data=0.
  - state=IDLE, WEL=0, bit counter=0, shift registers=0.
  - Memory contents are not reset (undefined at power-up, preserved across rst).
- Sync and edge detect:
  - sck, csn and mosi pass through SYNC_STAGES flops.
  - Rise/fall of sck is detected from the last two synced samples.
  - Master must hold sck high and low each ≥ SYNC_STAGES+2 clk cycles (clk ≥ 8× sck at defaults).
- SPI mode 0:
  - mosi is sampled on detected sck rise.
  - miso changes on detected sck fall.
  - The first bit of a response byte is presented on the fall after the last rise of the preceding byte.
- Chip select:
  - csn synced high → state IDLE, bit counter cleared, miso=0. Any partial byte is discarded.
  - csn synced fall → state CMD.
  - csn has priority over an sck edge in the same cycle.
- States:
  - IDLE: wait for csn low.
  - CMD: shift 8 bits, then decode the command.
    - 0x03 READ → ADDR.
    - 0x02 WRITE → ADDR if WEL=1, else IGNORE.
    - 0x06 WREN → set WEL, go to IGNORE.
    - 0x04 WRDI → clear WEL, go to IGNORE.
    - 0x05 RDSR → STATUS.
    - Any other command → IGNORE.
  - ADDR: shift 8 bits. The low ADDR_W bits form the pointer; the MSB is ignored. Then go to RD_DATA or WR_DATA.
  - RD_DATA:
    - Load mem[ptr] into the output shifter on the fall that begins each byte.
    - After 8 bits, ptr increments and wraps at depth (0x7F→0x00).
    - Streams until csn rises.
  - WR_DATA:
    - After each 8th rise: mem[ptr] ← byte, wr_stb=1 for exactly one clk with wr_addr=ptr and wr_data=byte.
    - ptr then increments within the page: upper bits fixed, low log2(PAGE_SIZE) bits wrap (0x1F→0x10).
  - STATUS: repeatedly shifts out {6'b0, WEL, 1'b0} (bit0 WIP always 0) until csn rises.
  - IGNORE: miso=0; mosi is discarded until csn rises.
- WEL:
  - Cleared on the csn rise that ends a WRITE transaction, whether or not any data byte was committed.
  - WREN/WRDI take effect at the end of the command byte.
- Read-after-write: a byte committed in one transaction is readable in the next transaction.
- Reset mid-transaction: returns to IDLE immediately. No wr_stb is issued for a partial byte. The synchronisers restart, so a transaction already in flight is ignored until csn goes high then low again.

Test Plan:
- Reset → miso=0, wr_stb=0. RDSR (0x05) then reads 0x00.
- WREN (0x06), csn high, RDSR → 0x02. WRDI (0x04), RDSR → 0x00.
- WREN; WRITE 0x02, addr 0x10, data 0xA5,0x5A → wr_stb pulses twice: (0x10,0xA5), (0x11,0x5A). Then READ 0x03 addr 0x10, 2 bytes → miso shows 0xA5,0x5A. RDSR → 0x00 (WEL auto-cleared).
- WRITE without WREN: 0x02, addr 0x20, 0xFF → no wr_stb. READ 0x20 returns the prior contents.
- Page wrap: WREN; WRITE addr 0x1E, bytes 0x01,0x02,0x03 → wr_addr 0x1E,0x1F,0x10. READ wrap: READ addr 0x7F, 2 bytes → mem[0x7F], mem[0x00].
- csn raised after 5 bits of a data byte → no wr_stb, state IDLE. Assert rst mid-READ → miso=0 next cycle, next transaction decodes normally.
